uart_rx_oversampled: RTL and testbench
======================================

// Module: uart_rx_oversampled
// PURPOSE
//  Serial-to-parallel UART receiver with internal 16x oversampling baud-tick generator.
//  Sits directly upstream of the command/operand interface FSM; drives its rx_done/rx_data inputs.
//  Recovers 8N1 frames: one start bit, DBIT data bits LSB first, no parity, one stop bit.
//  Presents each valid byte with a one-cycle done strobe and flags framing errors separately.
// PARAMETERS
//  DBIT      8    data bits per frame
//  SB_TICK   16   oversampling ticks spent in stop bit (16 = 1 stop bit)
//  BAUD_DIV  326  clocks per oversample tick (100 MHz / (19200*16)); must be >= 2
// PORTS
//  i_clk         in   1     system clock, all logic on rising edge
//  i_reset       in   1     asynchronous, active-low reset
//  i_rx          in   1     serial line, idle high, asynchronous to i_clk
//  o_rx_done     out  1     one-cycle pulse: o_rx_data holds a new valid byte
//  o_rx_data     out  DBIT  last correctly received byte
//  o_frame_err   out  1     one-cycle pulse: stop bit sampled low
//  o_busy        out  1     high while state != IDLE
// BEHAVIOUR
//  Reset (i_reset=0, async): state=IDLE, s=0, n=0, shift reg=0, baud cnt=0, sync flops=1;
//   o_rx_done=0, o_rx_data=0, o_frame_err=0, o_busy=0. Reset mid-frame aborts the frame, no strobe.
//  Input sync: 2-flop synchronizer on i_rx; FSM sees only rx_s (2-cycle line latency).
//  Baud gen: free-running counter 0..BAUD_DIV-1; tick=1 for exactly one clock when cnt==BAUD_DIV-1,
//   then wraps to 0. Never reset by the FSM.
//  Counters: s (4 bit) oversample count; n (log2 DBIT) bit index. All FSM advances gated by tick.
//  FSM:
//   IDLE : rx_s==0 -> START, s=0 (checked every clock, not only on tick).
//   START: on tick: s==7 -> (rx_s==0 ? DATA, s=0, n=0 : IDLE glitch reject); else s++.
//   DATA : on tick: s==15 -> s=0, b={rx_s, b[DBIT-1:1]}; n==DBIT-1 -> STOP else n++; else s++.
//   STOP : on tick: s==SB_TICK-1 -> IDLE; rx_s==1: o_rx_data<=b, o_rx_done=1 next cycle;
//          rx_s==0: o_frame_err=1 next cycle, o_rx_data unchanged, no o_rx_done; else s++.
//  Sample point: mid-bit (start confirmed at tick 8, data every 16 ticks thereafter).
//  Strobes: o_rx_done/o_frame_err registered, high exactly one clock, never both high together.
//  o_rx_data: stable between done strobes; never changes on a framing error.
//  Line held low (break): frame errors, returns IDLE, re-enters START at once; repeats per frame.
//  Back-to-back frames: start edge immediately after stop sample is accepted; no idle gap needed.
//  Tolerance: correct reception for transmitter baud within +/-3% of nominal.
// TESTING (bench uses BAUD_DIV=4 -> 64 clocks per bit)
//  1. Frame 0x64 -> exactly one o_rx_done pulse, o_rx_data=0x64, o_frame_err never high.
//  2. Back-to-back 0x64,0x05,0x64,0x0A,0x6F,0x20, no gap -> six done pulses, data in that order.
//  3. i_rx low 16 clocks then high -> no strobe, o_busy returns 0 within 40 clocks, data unchanged.
//  4. Frame 0xA5 with stop bit 0 after valid 0x64 -> one o_frame_err pulse, no done, o_rx_data=0x64.
//  5. i_reset low during data bit 3 of 0x3C -> all outputs 0 at once; next 0x3C frame received.
//  6. Transmitter bit time 62 and 66 clocks, frame 0x96 -> o_rx_data=0x96, no frame error.

Source files
------------

// File: rtl/uart_rx_oversampled_if.sv
// Serial line and received-byte bundle for uart_rx_oversampled.
// The receiver uses the slave view; the line driver/byte consumer uses master.
interface uart_rx_oversampled_if #(
  parameter int unsigned DBIT = 8
);
  logic            i_rx;
  logic            o_rx_done;
  logic [DBIT-1:0] o_rx_data;
  logic            o_frame_err;
  logic            o_busy;

  modport master (
    output i_rx,
    input  o_rx_done,
    input  o_rx_data,
    input  o_frame_err,
    input  o_busy
  );

  modport slave (
    input  i_rx,
    output o_rx_done,
    output o_rx_data,
    output o_frame_err,
    output o_busy
  );
endinterface

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver with a free-running 16x oversampling tick generator.
// Emits one-cycle done / framing-error strobes; o_rx_data only updates on good frames.
module uart_rx_oversampled #(
  parameter int unsigned DBIT     = 8,
  parameter int unsigned SB_TICK  = 16,
  parameter int unsigned BAUD_DIV = 326
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  uart_rx_oversampled_if.slave rx_if
);
  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] data_q, data_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic [CW-1:0]   cnt_q;
  logic            tick;
  logic            rx_meta_q, rx_s_q;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_if.i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign tick = (cnt_q == CW'(BAUD_DIV - 1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Start edge is looked for every clock, not only on ticks.
        if (!rx_s_q) begin
          state_d = S_START;
          s_d     = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (s_q == 4'd7) begin
            if (!rx_s_q) begin
              state_d = S_DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (s_q == 4'd15) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[DBIT-1:1]};
            if (n_q == NW'(DBIT - 1)) begin
              state_d = S_STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (s_q == 4'(SB_TICK - 1)) begin
            state_d = S_IDLE;
            if (rx_s_q) begin
              data_d = b_q;
              done_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_if.o_rx_done   = done_q;
  assign rx_if.o_rx_data   = data_q;
  assign rx_if.o_frame_err = ferr_q;
  assign rx_if.o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed + randomized bench for uart_rx_oversampled; a byte-level model predicts
// which frames must be delivered, which must flag a framing error, and the held data.
module tb_uart_rx_oversampled;
  localparam int BIT = 64;

  logic clk = 1'b0;
  logic rst_n;

  uart_rx_oversampled_if #(.DBIT(8)) rx_if ();

  uart_rx_oversampled #(
    .DBIT    (8),
    .SB_TICK (16),
    .BAUD_DIV(4)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .rx_if  (rx_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_data = 8'h00;
  int         exp_ferr = 0;

  logic [7:0] got_q[$];
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         stab_err = 0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_rst = 1'b0;

  always @(negedge clk) begin
    if (rx_if.o_rx_done) got_q.push_back(rx_if.o_rx_data);
    if (rx_if.o_frame_err) ferr_cnt++;
    if (rx_if.o_rx_done && rx_if.o_frame_err) both_cnt++;
    if (rst_n && prev_rst && !rx_if.o_rx_done && rx_if.o_rx_data !== prev_data) stab_err++;
    prev_data = rx_if.o_rx_data;
    prev_rst  = rst_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int bit_clks, input logic stop_bit,
                            input int stop_clks);
    rx_if.i_rx = 1'b0;
    repeat (bit_clks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_if.i_rx = d[i];
      repeat (bit_clks) @(negedge clk);
    end
    rx_if.i_rx = stop_bit;
    repeat (stop_clks) @(negedge clk);
    rx_if.i_rx = 1'b1;
  endtask

  task automatic tx_good(input logic [7:0] d, input int bit_clks);
    send_frame(d, bit_clks, 1'b1, bit_clks);
    exp_q.push_back(d);
    exp_data = d;
  endtask

  // Stop bit held low well past its centre, then released before the receiver
  // could confirm a second start, so exactly one framing error results.
  task automatic tx_bad(input logic [7:0] d);
    send_frame(d, BIT, 1'b0, BIT / 2 + 12);
    exp_ferr++;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (!rx_if.o_busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, ".byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, ".ferr"}, 32'(ferr_cnt), 32'(exp_ferr));
    check({tag, ".data"}, 32'(rx_if.o_rx_data), 32'(exp_data));
    check({tag, ".both"}, 32'(both_cnt), 32'd0);
    check({tag, ".stable"}, 32'(stab_err), 32'd0);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".done"}, 32'(rx_if.o_rx_done), 32'd0);
    check({tag, ".data"}, 32'(rx_if.o_rx_data), 32'd0);
    check({tag, ".ferr"}, 32'(rx_if.o_frame_err), 32'd0);
    check({tag, ".busy"}, 32'(rx_if.o_busy), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         ok;
    logic [7:0] d;
    logic [7:0] seq [6];
    seq = '{8'h64, 8'h05, 8'h64, 8'h0A, 8'h6F, 8'h20};

    rx_if.i_rx = 1'b1;
    rst_n      = 1'b0;
    repeat (4) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    tx_good(8'h64, BIT);
    wait_idle(200, ok);
    check("single.idle", 32'(ok), 32'd1);
    compare_model("single");

    for (int i = 0; i < 6; i++) tx_good(seq[i], BIT);
    wait_idle(200, ok);
    check("b2b.idle", 32'(ok), 32'd1);
    compare_model("b2b");

    repeat (40) @(negedge clk);
    rx_if.i_rx = 1'b0;
    repeat (16) @(negedge clk);
    check("glitch.busy", 32'(rx_if.o_busy), 32'd1);
    rx_if.i_rx = 1'b1;
    wait_idle(40, ok);
    check("glitch.idle", 32'(ok), 32'd1);
    repeat (20) @(negedge clk);
    compare_model("glitch");

    tx_good(8'h64, BIT);
    repeat (20) @(negedge clk);
    tx_bad(8'hA5);
    repeat (80) @(negedge clk);
    wait_idle(200, ok);
    check("ferr.idle", 32'(ok), 32'd1);
    compare_model("ferr");

    repeat (40) @(negedge clk);
    fork
      send_frame(8'h3C, BIT, 1'b1, BIT);
      begin
        repeat (BIT * 4 + BIT / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
      end
    join
    exp_data = 8'h00;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    compare_model("postreset");
    tx_good(8'h3C, BIT);
    wait_idle(200, ok);
    check("recover.idle", 32'(ok), 32'd1);
    compare_model("recover");

    repeat (40) @(negedge clk);
    tx_good(8'h96, 62);
    repeat (80) @(negedge clk);
    tx_good(8'h96, 66);
    wait_idle(200, ok);
    check("tol.idle", 32'(ok), 32'd1);
    compare_model("tol");

    for (int i = 0; i < 12; i++) begin
      repeat (40) @(negedge clk);
      d = 8'($urandom);
      if ($urandom_range(0, 3) == 0) tx_bad(d);
      else tx_good(d, int'($urandom_range(62, 66)));
      repeat (80) @(negedge clk);
    end
    wait_idle(200, ok);
    check("rand.idle", 32'(ok), 32'd1);
    compare_model("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
